// File: rtl/writebooster_v2_pkg.sv
// Shared types and constants for the writebooster_v2 AXI4 traffic master.
// Imported by the master and its pattern generator.
package writebooster_v2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_WR_CHECK  = 2'b00;
  localparam logic [1:0] MODE_WR_ONLY   = 2'b01;
  localparam logic [1:0] MODE_RD_CHECK  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Bytes covered by one burst; also the address stride between bursts.
  function automatic int unsigned burst_bytes(input int unsigned burst_len,
                                               input int unsigned data_width);
    return burst_len * (data_width / 8);
  endfunction

endpackage

// File: rtl/writebooster_v2_pattern.sv
// Seeded beat-value generator: loads the seed, then steps by one per accepted beat.
// One instance produces write data, a second one produces the read expectation.
module writebooster_v2_pattern #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= seed;
    end else if (advance) begin
      value <= value + DW'(1);
    end
  end

endmodule

// File: rtl/writebooster_v2_master.sv
// AXI4 full-master traffic generator: writes a seeded incrementing pattern in
// fixed-length INCR bursts, reads it back, and counts mismatches and bad responses.
module writebooster_v2_master
  import writebooster_v2_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_BURST_LEN  = 16,
  parameter int unsigned C_NUM_BURSTS       = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR =
    C_M_AXI_ADDR_WIDTH'(32'h4000_0000),
  parameter int unsigned C_ERR_CNT_WIDTH    = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            INIT_AXI_TXN,
  input  logic [1:0]                      MODE,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   SEED,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [C_ERR_CNT_WIDTH-1:0]      ERR_COUNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned AW      = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW      = C_M_AXI_DATA_WIDTH;
  localparam int unsigned BYTES   = burst_bytes(C_M_AXI_BURST_LEN, DW);
  localparam int unsigned BEAT_W  = $clog2(C_M_AXI_BURST_LEN + 1);
  localparam int unsigned BURST_W = $clog2(C_NUM_BURSTS + 1);

  localparam logic [BEAT_W-1:0]  LAST_BEAT    = BEAT_W'(C_M_AXI_BURST_LEN - 1);
  localparam logic [BURST_W-1:0] LAST_BURST   = BURST_W'(C_NUM_BURSTS - 1);
  localparam logic [AW-1:0]      BURST_STRIDE = AW'(BYTES);

  if (DW != 32 && DW != 64 && DW != 128) begin : g_bad_width
    $error("C_M_AXI_DATA_WIDTH must be 32, 64 or 128");
  end
  if (C_M_AXI_BURST_LEN < 1 || C_M_AXI_BURST_LEN > 256) begin : g_bad_len
    $error("C_M_AXI_BURST_LEN must be in 1..256");
  end
  if (C_NUM_BURSTS < 1 || C_NUM_BURSTS > 1024) begin : g_bad_count
    $error("C_NUM_BURSTS must be in 1..1024");
  end
  if (BYTES > 4096) begin : g_bad_burst
    $error("one burst must not cross a 4 KiB boundary");
  end
  if ((C_M_TARGET_SLAVE_BASE_ADDR % BURST_STRIDE) != '0) begin : g_bad_base
    $error("base address must be aligned to one burst");
  end

  state_t                 state, state_next;
  logic                   init_q;
  logic [1:0]             mode_q;
  logic [BEAT_W-1:0]      beat_idx;
  logic [BURST_W-1:0]     burst_idx;
  logic [AW-1:0]          burst_addr;
  logic                   aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic                   txn_done, err_flag;
  logic [C_ERR_CNT_WIDTH-1:0] err_count;
  logic [DW-1:0]          wr_value, rd_expect;

  logic       start;
  logic [1:0] start_mode;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic       last_beat, last_burst;
  logic       beat_err;

  assign start      = INIT_AXI_TXN & ~init_q & ((state == ST_IDLE) | (state == ST_DONE));
  assign start_mode = (MODE == 2'b11) ? MODE_WR_CHECK : MODE;

  assign aw_hs = aw_valid & M_AXI_AWREADY;
  assign w_hs  = w_valid  & M_AXI_WREADY;
  assign b_hs  = b_ready  & M_AXI_BVALID;
  assign ar_hs = ar_valid & M_AXI_ARREADY;
  assign r_hs  = r_ready  & M_AXI_RVALID;

  assign last_beat  = (beat_idx == LAST_BEAT);
  assign last_burst = (burst_idx == LAST_BURST);

  // Data, response and RLAST problems on one beat collapse into a single error.
  assign beat_err = (b_hs & (M_AXI_BRESP != AXI_RESP_OKAY)) |
                    (r_hs & ((M_AXI_RDATA != rd_expect) |
                             (M_AXI_RRESP != AXI_RESP_OKAY) |
                             (M_AXI_RLAST != last_beat)));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE:
        if (start) state_next = (start_mode == MODE_RD_CHECK) ? ST_RD_ADDR : ST_WR_ADDR;
      ST_WR_ADDR:
        if (aw_hs) state_next = ST_WR_DATA;
      ST_WR_DATA:
        if (w_hs && last_beat) state_next = ST_WR_RESP;
      ST_WR_RESP:
        if (b_hs) begin
          if (!last_burst)                 state_next = ST_WR_ADDR;
          else if (mode_q == MODE_WR_ONLY) state_next = ST_DONE;
          else                             state_next = ST_RD_ADDR;
        end
      ST_RD_ADDR:
        if (ar_hs) state_next = ST_RD_DATA;
      ST_RD_DATA:
        if (r_hs && last_beat) state_next = last_burst ? ST_DONE : ST_RD_ADDR;
      default:
        state_next = ST_IDLE;
    endcase
  end

  // Channel controls are flops loaded from the next state, so no READY input
  // ever reaches a VALID output combinationally.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      init_q     <= 1'b0;
      mode_q     <= MODE_WR_CHECK;
      beat_idx   <= '0;
      burst_idx  <= '0;
      burst_addr <= '0;
      aw_valid   <= 1'b0;
      w_valid    <= 1'b0;
      b_ready    <= 1'b0;
      ar_valid   <= 1'b0;
      r_ready    <= 1'b0;
      txn_done   <= 1'b0;
      err_flag   <= 1'b0;
      err_count  <= '0;
    end else begin
      state    <= state_next;
      init_q   <= INIT_AXI_TXN;
      aw_valid <= (state_next == ST_WR_ADDR);
      w_valid  <= (state_next == ST_WR_DATA);
      b_ready  <= (state_next == ST_WR_RESP);
      ar_valid <= (state_next == ST_RD_ADDR);
      r_ready  <= (state_next == ST_RD_DATA);
      txn_done <= (state_next == ST_DONE);
      if (start) begin
        mode_q     <= start_mode;
        beat_idx   <= '0;
        burst_idx  <= '0;
        burst_addr <= C_M_TARGET_SLAVE_BASE_ADDR;
        err_flag   <= 1'b0;
        err_count  <= '0;
      end else begin
        if (w_hs || r_hs) begin
          beat_idx <= last_beat ? '0 : beat_idx + BEAT_W'(1);
        end
        // The write phase hands over to the read phase at the base address.
        if (b_hs || (r_hs && last_beat)) begin
          if (last_burst) begin
            burst_idx  <= '0;
            burst_addr <= C_M_TARGET_SLAVE_BASE_ADDR;
          end else begin
            burst_idx  <= burst_idx + BURST_W'(1);
            burst_addr <= burst_addr + BURST_STRIDE;
          end
        end
        if (beat_err) begin
          err_flag <= 1'b1;
          if (err_count != '1) err_count <= err_count + C_ERR_CNT_WIDTH'(1);
        end
      end
    end
  end

  writebooster_v2_pattern #(.DW(DW)) u_wr_pattern (
    .clk     (ACLK),
    .rst     (ARESET),
    .load    (start),
    .advance (w_hs),
    .seed    (SEED),
    .value   (wr_value)
  );

  writebooster_v2_pattern #(.DW(DW)) u_rd_pattern (
    .clk     (ACLK),
    .rst     (ARESET),
    .load    (start),
    .advance (r_hs),
    .seed    (SEED),
    .value   (rd_expect)
  );

  assign TXN_DONE  = txn_done;
  assign ERROR     = err_flag;
  assign ERR_COUNT = err_count;

  assign M_AXI_AWADDR  = burst_addr;
  assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
  assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWVALID = aw_valid;

  assign M_AXI_WDATA  = wr_value;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_WLAST  = w_valid & last_beat;
  assign M_AXI_WVALID = w_valid;

  assign M_AXI_BREADY = b_ready;

  assign M_AXI_ARADDR  = burst_addr;
  assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
  assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARVALID = ar_valid;

  assign M_AXI_RREADY = r_ready;

endmodule

// File: tb/tb_writebooster_v2_master.sv
// Self-checking bench: a randomised AXI memory slave with fault injection,
// plus a pattern/address/error-count reference model for writebooster_v2_master.
module tb_writebooster_v2_master;

  localparam int unsigned DW          = 64;
  localparam int unsigned BL          = 8;
  localparam int unsigned NB          = 4;
  localparam int unsigned BEAT_BYTES  = DW / 8;
  localparam int unsigned BURST_BYTES = BL * BEAT_BYTES;
  localparam logic [31:0] BASE        = 32'h4000_0000;
  localparam int unsigned ERRW        = 2;
  localparam int unsigned ERR_MAX     = (1 << ERRW) - 1;

  logic            aclk = 1'b0;
  logic            areset;
  logic            init_txn;
  logic [1:0]      mode_in;
  logic [DW-1:0]   seed_in;
  logic            txn_done, error_flag;
  logic [ERRW-1:0] err_count;
  logic [31:0]     awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic            arvalid, arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;

  int check_count = 0;
  int error_count = 0;

  // Slave configuration and reference-model state for the current pass.
  logic [63:0] cur_seed;
  bit          bp_en;
  int          slverr_burst;
  logic [31:0] corrupt_mask;
  int aw_count, ar_count, w_global, r_global, w_beat, r_beat, b_burst, model_errs;
  bit b_fire, r_fire;
  logic [31:0] aw_q[$];
  logic [31:0] ar_q[$];
  int          b_q[$];
  logic [63:0] mem [logic [31:0]];

  writebooster_v2_master #(
    .C_M_AXI_ADDR_WIDTH         (32),
    .C_M_AXI_DATA_WIDTH         (DW),
    .C_M_AXI_BURST_LEN          (BL),
    .C_NUM_BURSTS               (NB),
    .C_M_TARGET_SLAVE_BASE_ADDR (BASE),
    .C_ERR_CNT_WIDTH            (ERRW)
  ) dut (
    .ACLK          (aclk),
    .ARESET        (areset),
    .INIT_AXI_TXN  (init_txn),
    .MODE          (mode_in),
    .SEED          (seed_in),
    .TXN_DONE      (txn_done),
    .ERROR         (error_flag),
    .ERR_COUNT     (err_count),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWLEN   (awlen),
    .M_AXI_AWSIZE  (awsize),
    .M_AXI_AWBURST (awburst),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WLAST   (wlast),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARLEN   (arlen),
    .M_AXI_ARSIZE  (arsize),
    .M_AXI_ARBURST (arburst),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RLAST   (rlast),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic bit randReady();
    return !bp_en || ($urandom_range(0, 2) != 0);
  endfunction

  // One slave decision per negedge: DUT outputs are stable here and hold until
  // the next posedge, so a handshake decided now is the one that edge completes.
  task automatic slaveStep();
    logic [31:0] a;
    logic [63:0] d;
    if (areset) begin
      aw_q.delete(); ar_q.delete(); b_q.delete();
      w_beat = 0; r_beat = 0; b_fire = 0; r_fire = 0;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
      return;
    end
    if (b_fire) begin bvalid = 0; b_fire = 0; end
    if (r_fire) begin rvalid = 0; r_fire = 0; end

    if (!bvalid && b_q.size() > 0 && randReady()) begin
      bvalid = 1;
      bresp  = (b_q[0] == slverr_burst) ? 2'b10 : 2'b00;
    end
    if (bvalid && bready) begin
      b_fire = 1;
      if (bresp != 2'b00) model_errs++;
      void'(b_q.pop_front());
    end

    if (!rvalid && ar_q.size() > 0 && randReady()) begin
      a = ar_q[0] + 32'(r_beat * BEAT_BYTES);
      d = mem.exists(a) ? mem[a] : 64'd0;
      if (corrupt_mask[5'(r_global)]) d = d ^ 64'h1;
      rdata  = d;
      rresp  = 2'b00;
      rlast  = (r_beat == BL - 1);
      rvalid = 1;
    end
    if (rvalid && rready) begin
      r_fire = 1;
      if (rdata != cur_seed + 64'(r_global)) model_errs++;
      r_global++;
      if (r_beat == BL - 1) begin
        r_beat = 0;
        void'(ar_q.pop_front());
      end else begin
        r_beat++;
      end
    end

    wready = randReady();
    if (wvalid && wready) begin
      checkOutput("w_after_aw", 64'(aw_q.size() != 0), 64'd1);
      a = ((aw_q.size() != 0) ? aw_q[0] : 32'd0) + 32'(w_beat * BEAT_BYTES);
      mem[a] = wdata;
      checkOutput("wdata", wdata, cur_seed + 64'(w_global));
      checkOutput("wlast", 64'(wlast), 64'(w_beat == BL - 1));
      checkOutput("wstrb", 64'(wstrb), 64'hFF);
      w_global++;
      if (w_beat == BL - 1) begin
        w_beat = 0;
        b_q.push_back(b_burst);
        b_burst++;
        if (aw_q.size() != 0) void'(aw_q.pop_front());
      end else begin
        w_beat++;
      end
    end

    awready = randReady();
    if (awvalid && awready) begin
      checkOutput("awaddr", 64'(awaddr), 64'(BASE + 32'(aw_count * BURST_BYTES)));
      checkOutput("aw_attr", 64'({awlen, awsize, awburst}), 64'({8'd7, 3'd3, 2'b01}));
      aw_q.push_back(awaddr);
      aw_count++;
    end

    arready = randReady();
    if (arvalid && arready) begin
      checkOutput("araddr", 64'(araddr), 64'(BASE + 32'(ar_count * BURST_BYTES)));
      checkOutput("ar_attr", 64'({arlen, arsize, arburst}), 64'({8'd7, 3'd3, 2'b01}));
      ar_q.push_back(araddr);
      ar_count++;
    end
  endtask

  initial begin
    forever begin
      @(negedge aclk);
      slaveStep();
    end
  end

  task automatic startPass(input logic [1:0] mode, input logic [63:0] seed,
                           input bit bp, input int slv_b, input logic [31:0] cmask);
    @(posedge aclk); #2;
    cur_seed = seed; bp_en = bp; slverr_burst = slv_b; corrupt_mask = cmask;
    aw_count = 0; ar_count = 0; w_global = 0; r_global = 0; b_burst = 0; model_errs = 0;
    mode_in  = mode;
    seed_in  = seed;
    init_txn = 1;
    @(posedge aclk); #2;
    init_txn = 0;
    checkOutput("start_done_clr", 64'(txn_done), 64'd0);
    checkOutput("start_err_clr", 64'(error_flag), 64'd0);
    checkOutput("start_cnt_clr", 64'(err_count), 64'd0);
  endtask

  task automatic finishPass(input logic [1:0] mode, input bit mid_init);
    int cyc = 0;
    bit done_seen = 0;
    bit writes = (mode != 2'b10);
    bit reads  = (mode != 2'b01);
    int exp_cnt;
    while (cyc < 3000) begin
      @(negedge aclk);
      if (txn_done) begin
        done_seen = 1;
        break;
      end
      cyc++;
      if (mid_init && cyc == 20) init_txn = 1;
      if (mid_init && cyc == 22) init_txn = 0;
    end
    exp_cnt = (model_errs > int'(ERR_MAX)) ? int'(ERR_MAX) : model_errs;
    checkOutput("txn_done", 64'(done_seen), 64'd1);
    checkOutput("aw_count", 64'(aw_count), writes ? 64'(NB) : 64'd0);
    checkOutput("w_beats", 64'(w_global), writes ? 64'(NB * BL) : 64'd0);
    checkOutput("ar_count", 64'(ar_count), reads ? 64'(NB) : 64'd0);
    checkOutput("r_beats", 64'(r_global), reads ? 64'(NB * BL) : 64'd0);
    checkOutput("error", 64'(error_flag), 64'(model_errs != 0));
    checkOutput("err_count", 64'(err_count), 64'(exp_cnt));
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [63:0] seed,
                               input bit bp, input int slv_b, input logic [31:0] cmask,
                               input bit mid_init);
    startPass(mode, seed, bp, slv_b, cmask);
    finishPass(mode, mid_init);
  endtask

  initial begin
    logic [63:0] wrap_seed;
    int cyc;
    wrap_seed = 64'hFFFF_FFFF_FFFF_FFFE;
    areset = 1; init_txn = 0; mode_in = 0; seed_in = 0;
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    bp_en = 0; slverr_burst = -1; corrupt_mask = 0; cur_seed = 0;
    repeat (3) @(posedge aclk);
    #2;
    checkOutput("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    checkOutput("rst_done", 64'(txn_done), 64'd0);
    checkOutput("rst_error", 64'(error_flag), 64'd0);
    checkOutput("rst_errcnt", 64'(err_count), 64'd0);
    checkOutput("rst_awaddr", 64'(awaddr), 64'd0);
    checkOutput("rst_araddr", 64'(araddr), 64'd0);
    areset = 0;

    $display("[TB] pass: MODE=00 SEED=1, slave always ready");
    applyStimulus(2'b00, 64'd1, 0, -1, 32'd0, 0);

    $display("[TB] pass: MODE=11 random seed with backpressure");
    applyStimulus(2'b11, {$urandom, $urandom}, 1, -1, 32'd0, 0);

    $display("[TB] pass: MODE=01 then MODE=10 with wrapping seed");
    applyStimulus(2'b01, wrap_seed, 1, -1, 32'd0, 0);
    applyStimulus(2'b10, wrap_seed, 1, -1, 32'd0, 0);

    $display("[TB] pass: MODE=10 with read beat 5 corrupted");
    applyStimulus(2'b10, wrap_seed, 1, -1, 32'h0000_0020, 0);

    $display("[TB] pass: SLVERR on burst 2 plus five corrupted read beats");
    applyStimulus(2'b00, {$urandom, $urandom}, 1, 2, 32'h8010_0602, 0);

    $display("[TB] reset asserted during write data");
    startPass(2'b00, {$urandom, $urandom}, 1, -1, 32'd0);
    cyc = 0;
    while (w_global < 3 && cyc < 500) begin
      @(negedge aclk);
      cyc++;
    end
    checkOutput("reach_wdata", 64'(w_global >= 3), 64'd1);
    @(posedge aclk); #2;
    areset = 1;
    @(negedge aclk);
    checkOutput("mid_rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    checkOutput("mid_rst_done", 64'(txn_done), 64'd0);
    checkOutput("mid_rst_flags", 64'({error_flag, err_count}), 64'd0);
    checkOutput("mid_rst_addr", 64'({awaddr, araddr}), 64'd0);
    repeat (2) @(posedge aclk);
    #2;
    areset = 0;

    $display("[TB] clean pass after reset, with a stray INIT pulse mid-run");
    applyStimulus(2'b00, {$urandom, $urandom}, 1, -1, 32'd0, 1);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
